fmul_csa_adder: RTL
===================

# fmul_csa_adder

Parametrised, pipelined carry-propagate adder that collapses the sum/carry vectors leaving a multiplier's carry-save reduction tree into one binary result. It replaces the single-cycle full-width final adder of the multiplier datapath. The carry chain is split into SEGS equal segments, one per pipeline stage. A valid/ready handshake on both sides lets the adder stall with downstream normalisation/rounding without losing data.

## Interface
- WIDTH, 40: operand and result width in bits. Must satisfy WIDTH % SEGS == 0.
- SEGS, 2: number of carry segments, which equals the pipeline depth. Legal range is 1..8. SW = WIDTH/SEGS.
- clk  in  1  clock; all state is updated on its rising edge.
- clrn  in  1  asynchronous active-low reset (clear).
- in_valid  in  1  z_sum/z_carry hold a valid operand pair.
- in_ready  out  1  adder accepts the pair this cycle.
- z_sum  in  WIDTH  partial-sum vector from the CSA tree.
- z_carry  in  WIDTH  partial-carry vector (already aligned) from the CSA tree.
- out_valid  out  1  z/cout hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- z  out  WIDTH  (z_sum + z_carry) mod 2^WIDTH.
- cout  out  1  bit WIDTH of the full sum (carry out of the top segment).

## Operation
- The pipeline has SEGS stages, each with a valid bit v[k] and data registers.
- Stage 1 adds segment 0 of sum and carry, registering SW result bits plus the carry.
- Stage k (k≥2) adds segment k-1 of the skewed raw operands plus the registered carry of stage k-1, then appends its result above the already-resolved lower bits.
- Raw upper segments travel alongside as skew registers. Once a segment is consumed, its skew bits are no longer stored.
- The final stage drives z/cout/out_valid directly from registers. There is no combinational path from the inputs to the outputs.
- Global advance = !out_valid || out_ready. On advance, every stage loads from its predecessor, bubbles included. Otherwise every stage holds.
- Without skid: in_ready = advance. A transfer occurs when in_valid && in_ready.
- Arithmetic is exact modulo 2^(WIDTH+1). There is no saturation and no sign handling.
- SEGS=1: a single registered full-width add with latency 1.
- Reset (clrn=0, at any time, including mid-stream): all v[k]=0, all data registers 0, out_valid=0, z=0, cout=0. In-flight operands are discarded. in_ready=1 while clrn is high and the pipe is empty.

## Timing
- Latency: SEGS cycles from the accepting edge to out_valid=1, with no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, z/cout/out_valid and all internal stages hold. No input is accepted.
- On an output stall, a bubble in a lower stage is not collapsed. The pipe freezes as a whole.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- When the pipe is empty with out_ready=0: advance=1, because out_valid=0. The pipe fills until the result reaches the output, then stalls.

## Configuration
- FMUL_CSA_ADDER_SKID_EN defined:
  - A one-entry input skid register is inserted ahead of stage 1.
  - in_ready is driven straight from a flop, as !skid_full.
  - With skid empty and advance=1, the input passes straight to stage 1.
  - With skid empty and advance=0, the input is captured into skid.
  - While skid is full, the skid entry enters stage 1 on the next advance, ahead of any new input.
  - Latency and throughput are unchanged when the skid is not occupied.
  - Reset clears skid_full.
- FMUL_CSA_ADDER_SKID_EN undefined:
  - There is no skid register.
  - in_ready = advance, a combinational path from out_ready.

## Test plan
- Carry across segment boundary (WIDTH=40, SEGS=2): sum=0xFFFFFFFFFF, carry=0x0000000001 -> after 2 cycles out_valid=1, z=0x0000000000, cout=1.
- Plain add: sum=0x123456789A, carry=0x0011111111 -> z=0x12456789AB, cout=0, latency 2. SEGS=1 build -> same value, latency 1.
- Streaming: 16 random pairs back-to-back with out_ready=1 -> 16 consecutive results, in order, matching a reference sum, one per cycle.
- Stall: out_ready=0 for 5 cycles while results are pending -> z/cout stable, no input accepted (non-skid), no loss or duplication after out_ready returns to 1.
- Reset mid-stream: clrn pulled low asynchronously between edges with 2 pairs in flight -> out_valid, z and cout drop to 0 immediately. After release the next pair produces a correct result with no stale output.
- Skid (FMUL_CSA_ADDER_SKID_EN): out_ready toggles at random -> in_ready is never combinationally dependent on out_ready, and all 64 results are correct and in order.

Source files
------------

// File: rtl/fmul_csa_adder.sv
// Segmented, pipelined carry-propagate adder that merges the CSA-tree sum/carry vectors.
// Define FMUL_CSA_ADDER_SKID_EN to add a one-entry input skid so in_ready comes straight from a flop.
module fmul_csa_adder #(
    parameter int WIDTH = 40,
    parameter int SEGS  = 2
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z_sum,
    input  logic [WIDTH-1:0] z_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout
);

    localparam int SW = WIDTH / SEGS;

    logic             advance;
    logic             head_vld;
    logic [WIDTH-1:0] head_sum;
    logic [WIDTH-1:0] head_carry;

    // Per-stage registers: acc_p holds resolved low bits plus the raw upper sum,
    // skc_p holds the raw upper carry (consumed segments are forced to zero).
    logic             vld_p [SEGS];
    logic             cy_p  [SEGS];
    logic [WIDTH-1:0] acc_p [SEGS];
    logic [WIDTH-1:0] skc_p [SEGS];

    logic             vld_nx [SEGS];
    logic             cy_nx  [SEGS];
    logic [WIDTH-1:0] acc_nx [SEGS];
    logic [WIDTH-1:0] skc_nx [SEGS];

    assign advance = !out_valid || out_ready;

`ifdef FMUL_CSA_ADDER_SKID_EN
    logic             skid_full;
    logic [WIDTH-1:0] skid_sum;
    logic [WIDTH-1:0] skid_carry;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            skid_full  <= 1'b0;
            skid_sum   <= '0;
            skid_carry <= '0;
        end else if (skid_full) begin
            if (advance)
                skid_full <= 1'b0;
        end else if (in_valid && !advance) begin
            skid_full  <= 1'b1;
            skid_sum   <= z_sum;
            skid_carry <= z_carry;
        end
    end

    assign in_ready   = !skid_full;
    assign head_vld   = skid_full || in_valid;
    assign head_sum   = skid_full ? skid_sum : z_sum;
    assign head_carry = skid_full ? skid_carry : z_carry;
`else
    assign in_ready   = advance;
    assign head_vld   = in_valid;
    assign head_sum   = z_sum;
    assign head_carry = z_carry;
`endif

    always_comb begin
        for (int s = 0; s < SEGS; s++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] c;
            logic             ci;
            logic             v;
            logic [SW:0]      seg;
            if (s == 0) begin
                a  = head_sum;
                c  = head_carry;
                ci = 1'b0;
                v  = head_vld;
            end else begin
                a  = acc_p[(s > 0) ? s - 1 : 0];
                c  = skc_p[(s > 0) ? s - 1 : 0];
                ci = cy_p[(s > 0) ? s - 1 : 0];
                v  = vld_p[(s > 0) ? s - 1 : 0];
            end
            seg = {1'b0, a[s*SW +: SW]} + {1'b0, c[s*SW +: SW]} + {{SW{1'b0}}, ci};
            acc_nx[s]            = a;
            acc_nx[s][s*SW +: SW] = seg[SW-1:0];
            skc_nx[s]            = c;
            skc_nx[s][s*SW +: SW] = '0;
            cy_nx[s]             = seg[SW];
            vld_nx[s]            = v;
        end
    end

    // Stage boundary: the whole pipe advances or holds together, bubbles included.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int s = 0; s < SEGS; s++) begin
                vld_p[s] <= 1'b0;
                cy_p[s]  <= 1'b0;
                acc_p[s] <= '0;
                skc_p[s] <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < SEGS; s++) begin
                vld_p[s] <= vld_nx[s];
                cy_p[s]  <= cy_nx[s];
                acc_p[s] <= acc_nx[s];
                skc_p[s] <= skc_nx[s];
            end
        end
    end

    assign out_valid = vld_p[SEGS-1];
    assign z         = acc_p[SEGS-1];
    assign cout      = cy_p[SEGS-1];

endmodule
